// File: rtl/serial_mag_comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator:
// FSM state encodings and the default operand width.
package cmp_pkg;

  localparam int CMP_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_mag_comparator_bit_slice.sv
// Combinational equal/greater slice. One bit pair per evaluation.
// MSB-first: only the first differing bit (while still equal) decides.
// LSB-first: every differing bit overwrites, so the most significant
// difference, seen last, wins.
module cmp_bit_slice (
  input  logic ai,
  input  logic bi,
  input  logic e_in,
  input  logic g_in,
  input  logic msb_first,
  output logic e_out,
  output logic g_out
);

  logic diff;
  logic take;

  assign diff = ai ^ bi;

  // In MSB-first order an earlier difference locks the result
  assign take = msb_first ? (e_in & diff) : diff;

  // Update the equal/greater pair only when this bit decides it
  always_comb begin
    e_out = e_in;
    g_out = g_in;
    if (take) begin
      e_out = 1'b0;
      g_out = ai;
    end
  end

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator. Operands are captured on an
// accepted start and scanned one bit per clock (LSB- or MSB-first)
// through a registered equal/greater chain; eq/gt/lt are reported with
// a one-cycle done pulse and held until the next start.
// Optional: SERIAL_CMP_EARLY_TERM_EN ends an MSB-first scan at the first
// differing bit.
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             msb_first,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   sa, sb;
  logic               mode;
  logic               e_q, g_q;
  logic [CNT_W-1:0]   cnt;
  logic               ai, bi;
  logic               e_nx, g_nx;
  logic               last_bit;
  logic               stop;
  logic               accept;
  logic               finish;

  // Active end of the shift registers depends on scan order
  assign ai = mode ? sa[WIDTH-1] : sa[0];
  assign bi = mode ? sb[WIDTH-1] : sb[0];

  cmp_bit_slice u_slice (
    .ai        (ai),
    .bi        (bi),
    .e_in      (e_q),
    .g_in      (g_q),
    .msb_first (mode),
    .e_out     (e_nx),
    .g_out     (g_nx)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_CMP_EARLY_TERM_EN
  // MSB-first: the first difference fully decides the result
  assign stop = last_bit | (mode & e_q & ~e_nx);
`else
  assign stop = last_bit;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state and datapath control; start only sampled in IDLE/DONE
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          finish   = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand capture, serial scan, bit counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      mode <= 1'b0;
      e_q  <= 1'b0;
      g_q  <= 1'b0;
      cnt  <= '0;
      eq   <= 1'b0;
      gt   <= 1'b0;
      lt   <= 1'b0;
    end else if (accept) begin
      sa   <= a;
      sb   <= b;
      mode <= msb_first;
      e_q  <= 1'b1;
      g_q  <= 1'b0;
      cnt  <= '0;
      eq   <= 1'b0;
      gt   <= 1'b0;
      lt   <= 1'b0;
    end else if (state == ST_RUN) begin
      sa  <= mode ? (sa << 1) : (sa >> 1);
      sb  <= mode ? (sb << 1) : (sb >> 1);
      e_q <= e_nx;
      g_q <= g_nx;
      cnt <= cnt + 1'b1;
      if (finish) begin
        eq <= e_nx;
        gt <= g_nx & ~e_nx;
        lt <= ~g_nx & ~e_nx;
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator: an 8-bit instance for the
// directed scenarios and a 4-bit instance for an exhaustive sweep.
module tb_serial_mag_comparator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       msb_first = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, eq, gt, lt;

  logic       start4 = 1'b0;
  logic       msb4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, eq4, gt4, lt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msb_first(msb_first),
    .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
  );

  serial_mag_comparator #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .msb_first(msb4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .eq(eq4), .gt(gt4), .lt(lt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a start; sync=1 waits for a falling edge first
  task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic m, input bit sync);
    if (sync) @(negedge clk);
    a = va; b = vb; msb_first = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'hxx; b = 8'hxx; msb_first = 1'bx;
  endtask

  // Count edges after the start edge until done; optionally pulse start mid-run
  task automatic wait_done(input int pulse_at, output int lat, output int bcnt);
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (lat < 40) begin
      if (lat == pulse_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (done) break;
      if (busy) bcnt++;
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] va, input logic [7:0] vb,
                      input logic m, input int exp_lat,
                      input logic xe, input logic xg, input logic xl);
    int lat, bc;
    launch(va, vb, m, 1'b1);
    wait_done(-1, lat, bc);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy"}, bc, exp_lat);
    chk({tag, "_res"}, {eq, gt, lt}, {xe, xg, xl});
  endtask

  localparam int EXP_MSB80 =
`ifdef SERIAL_CMP_EARLY_TERM_EN
    1;
`else
    8;
`endif
  localparam int EXP_MSB12 =
`ifdef SERIAL_CMP_EARLY_TERM_EN
    2;
`else
    8;
`endif

  initial begin
    int lat, bc, k, fails4;
    logic [2:0] ref3;
    logic [3:0] dx;

    // Reset state
    #12;
    chk("rst_outs", {busy, done, eq, gt, lt}, 5'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", {busy, done, eq, gt, lt}, 5'b0);

    // Main function
    run8("lsb_eq5a",  8'h5A, 8'h5A, 1'b0, 8, 1'b1, 1'b0, 1'b0);
    run8("msb_80_7f", 8'h80, 8'h7F, 1'b1, EXP_MSB80, 1'b0, 1'b1, 1'b0);
    run8("lsb_01_02", 8'h01, 8'h02, 1'b0, 8, 1'b0, 1'b0, 1'b1);
    run8("lsb_81_7f", 8'h81, 8'h7F, 1'b0, 8, 1'b0, 1'b1, 1'b0);
    run8("msb_12_52", 8'h12, 8'h52, 1'b1, EXP_MSB12, 1'b0, 1'b0, 1'b1);
    run8("msb_3c_3d", 8'h3C, 8'h3D, 1'b1, 8, 1'b0, 1'b0, 1'b1);
    run8("msb_eqff",  8'hFF, 8'hFF, 1'b1, 8, 1'b1, 1'b0, 1'b0);

    // Result holds after the done cycle
    repeat (3) @(posedge clk);
    #1;
    chk("hold_res", {busy, done, eq, gt, lt}, 5'b00100);

    // Back-to-back: start during DONE, plus an ignored start mid-run
    run8("b2b_first", 8'h40, 8'h20, 1'b0, 8, 1'b0, 1'b1, 1'b0);
    launch(8'h10, 8'h20, 1'b0, 1'b0);
    chk("b2b_run", {busy, done, eq, gt, lt}, 5'b10000);
    wait_done(3, lat, bc);
    chk("b2b_lat", lat, 8);
    chk("b2b_busy", bc, 8);
    chk("b2b_res", {eq, gt, lt}, 3'b001);
    @(posedge clk); #1;
    chk("done_pulse", {busy, done}, 2'b00);

    // Reset in the middle of a run
    launch(8'hC3, 8'h3C, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {busy, done, eq, gt, lt}, 5'b0);
    bc = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) bc++;
    end
    chk("mid_rst_nodone", bc, 0);
    @(negedge clk); rst_n = 1'b1;
    run8("post_rst", 8'hC3, 8'h3C, 1'b0, 8, 1'b0, 1'b1, 1'b0);

    // Exhaustive 4-bit sweep, both scan orders
    fails4 = 0;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          ref3 = (i == j) ? 3'b100 : (i > j) ? 3'b010 : 3'b001;
          k = 4;
`ifdef SERIAL_CMP_EARLY_TERM_EN
          dx = 4'(i ^ j);
          if (m == 1 && dx != 0) begin
            k = 4;
            for (int p = 0; p < 4; p++) if (dx[p]) k = 4 - p;
          end
`endif
          @(negedge clk);
          a4 = 4'(i); b4 = 4'(j); msb4 = m[0]; start4 = 1'b1;
          @(posedge clk); #1;
          start4 = 1'b0;
          lat = 0;
          while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done4) break;
          end
          checks++;
          assert ({eq4, gt4, lt4} === ref3 && lat == k &&
                  (32'(eq4) + 32'(gt4) + 32'(lt4)) == 1) else begin
            errors++;
            fails4++;
            $error("FAIL sweep4 m=%0d a=%0h b=%0h observed=%b lat=%0d expected=%b lat=%0d",
                   m, i, j, {eq4, gt4, lt4}, lat, ref3, k);
          end
        end
      end
    end
    chk("sweep4_total", fails4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
